// File: rtl/pp_pkg.sv
// Shared types and helpers for the pp_packer byte-to-word packer.
package pp_pkg;

  typedef logic [7:0] byte_t;

  // Width of the fill counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned nbyte);
    int unsigned w;
    w = $clog2(nbyte);
    return (w < 1) ? 1 : w;
  endfunction

  // Physical byte lane for the k-th accepted byte of a word.
  function automatic int unsigned lane_idx(input int unsigned k, input int unsigned nbyte,
                                           input bit lsb_first);
    return lsb_first ? k : (nbyte - 1 - k);
  endfunction

endpackage

// File: rtl/pp_out_slot.sv
// Single-entry valid/ready output register. A load always wins over a drain
// on the same edge, so back-to-back words leave no bubble.
module pp_out_slot #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] ldata,
  input  logic             oready,
  output logic             ovalid,
  output logic [WIDTH-1:0] data,
  output logic             free
);

  // Slot can take a new word when empty or being drained this cycle.
  assign free = !ovalid || oready;

  // Hold the word until the consumer takes it; clear on drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovalid <= 1'b0;
      data   <= '0;
    end else if (load) begin
      ovalid <= 1'b1;
      data   <= ldata;
    end else if (ovalid && oready) begin
      ovalid <= 1'b0;
      data   <= '0;
    end
  end

endmodule

// File: rtl/pp_packer.sv
// Packs NBYTE consecutive accepted bytes into one word on a valid/ready output.
// Optional feature macro: PP_PACKER_FLUSH_EN adds iflush (early end of word)
// and okeep (per-lane valid mask).
module pp_packer
  import pp_pkg::*;
#(
  parameter int unsigned NBYTE     = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ivalid,
  output logic               iready,
  input  byte_t              idata,
  output logic               ovalid,
  input  logic               oready,
`ifdef PP_PACKER_FLUSH_EN
  input  logic               iflush,
  output logic [NBYTE-1:0]   okeep,
`endif
  output logic [8*NBYTE-1:0] odata
);

  localparam int unsigned CW = cnt_width(NBYTE);
  localparam int unsigned WW = 8 * NBYTE;
`ifdef PP_PACKER_FLUSH_EN
  localparam int unsigned SW = WW + NBYTE;
`else
  localparam int unsigned SW = WW;
`endif

  logic [CW-1:0] cnt_q;
  logic [WW-1:0] asm_q;
  logic [WW-1:0] asm_ins;
  logic          last_byte;
  logic          is_final;
  logic          accept;
  logic          load;
  logic          slot_free;
  logic [SW-1:0] slot_ld;
  logic [SW-1:0] slot_q;

  assign last_byte = (cnt_q == CW'(NBYTE - 1));
`ifdef PP_PACKER_FLUSH_EN
  assign is_final  = last_byte || iflush;
`else
  assign is_final  = last_byte;
`endif

  // Only a word-closing byte can stall, and only when the slot cannot take it.
  assign iready = !is_final || slot_free;
  assign accept = ivalid && iready;
  assign load   = accept && is_final;

  // Assembly contents with the current byte merged into its lane.
  always_comb begin
    asm_ins = asm_q;
    asm_ins[8*lane_idx(32'(cnt_q), NBYTE, LSB_FIRST) +: 8] = idata;
  end

`ifdef PP_PACKER_FLUSH_EN
  logic [NBYTE-1:0] keep_ins;

  // Lanes 0..cnt (in arrival order) are filled once this byte lands.
  always_comb begin
    keep_ins = '0;
    for (int unsigned k = 0; k < NBYTE; k++) begin
      keep_ins[lane_idx(k, NBYTE, LSB_FIRST)] = (k <= 32'(cnt_q));
    end
  end

  assign slot_ld        = {keep_ins, asm_ins};
  assign {okeep, odata} = slot_q;
`else
  assign slot_ld = asm_ins;
  assign odata   = slot_q;
`endif

  // Fill counter and assembly register; both restart after a word closes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else if (accept) begin
      if (is_final) begin
        cnt_q <= '0;
        asm_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
        asm_q <= asm_ins;
      end
    end
  end

  pp_out_slot #(
    .WIDTH(SW)
  ) u_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .ldata (slot_ld),
    .oready(oready),
    .ovalid(ovalid),
    .data  (slot_q),
    .free  (slot_free)
  );

endmodule

// File: tb/tb_pp_packer.sv
// Bench for pp_packer: two instances (LSB-first and MSB-first) share stimulus
// and are checked against a byte-queue reference model.
module tb_pp_packer;

  localparam int unsigned NBYTE = 4;
`ifdef PP_PACKER_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                ivalid = 1'b0;
  logic [7:0]          idata = 8'h00;
  logic                oready = 1'b0;
  logic                iflush = 1'b0;
  logic                iready, iready_r;
  logic                ovalid, ovalid_r;
  logic [8*NBYTE-1:0]  odata, odata_r;
`ifdef PP_PACKER_FLUSH_EN
  logic [NBYTE-1:0]    okeep, okeep_r;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  pp_packer #(.NBYTE(NBYTE), .LSB_FIRST(1'b1)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .ivalid(ivalid),
    .iready(iready),
    .idata (idata),
    .ovalid(ovalid),
    .oready(oready),
`ifdef PP_PACKER_FLUSH_EN
    .iflush(iflush),
    .okeep (okeep),
`endif
    .odata (odata)
  );

  pp_packer #(.NBYTE(NBYTE), .LSB_FIRST(1'b0)) u_dut_r (
    .clk   (clk),
    .rst   (rst),
    .ivalid(ivalid),
    .iready(iready_r),
    .idata (idata),
    .ovalid(ovalid_r),
    .oready(oready),
`ifdef PP_PACKER_FLUSH_EN
    .iflush(iflush),
    .okeep (okeep_r),
`endif
    .odata (odata_r)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: accepted bytes collect in part; closed words queue in expq.
  typedef struct {
    logic [63:0] w;
    logic [63:0] wr;
    logic [15:0] k;
    logic [15:0] kr;
  } word_t;

  logic [7:0] part[$];
  word_t      expq[$];
  int         produced = 0;
  int         drained  = 0;
  bit         prev_hold = 1'b0;
  logic [63:0] prev_data;

  function automatic word_t build_word();
    word_t r;
    r.w = '0; r.wr = '0; r.k = '0; r.kr = '0;
    foreach (part[i]) begin
      r.w  = r.w  | (64'(part[i]) << (8 * i));
      r.wr = r.wr | (64'(part[i]) << (8 * (NBYTE - 1 - i)));
      r.k[i] = 1'b1;
      r.kr[NBYTE - 1 - i] = 1'b1;
    end
    return r;
  endfunction

  // Monitor at negedge: inputs are stable until the next rising edge.
  always @(negedge clk) begin
    bit ov_exp, fin;
    word_t nw;
    if (!rst) begin
      part.delete();
      expq.delete();
      prev_hold = 1'b0;
    end else begin
      ov_exp = (expq.size() != 0);
      check("ovalid", 64'(ovalid), 64'(ov_exp));
      check("ovalid_msb", 64'(ovalid_r), 64'(ov_exp));
      if (ov_exp) begin
        check("odata", 64'(odata), expq[0].w);
        check("odata_msb", 64'(odata_r), expq[0].wr);
`ifdef PP_PACKER_FLUSH_EN
        check("okeep", 64'(okeep), 64'(expq[0].k));
        check("okeep_msb", 64'(okeep_r), 64'(expq[0].kr));
`endif
      end
      if (prev_hold) check("stable", {31'd0, ovalid, odata}, prev_data);
      fin = (part.size() == NBYTE - 1) || (FLUSH && iflush);
      check("iready", 64'(iready), 64'(!fin || !ov_exp || oready));
      check("iready_msb", 64'(iready_r), 64'(!fin || !ov_exp || oready));
      // Commit the handshakes that the coming edge performs.
      if (ovalid && oready) begin
        drained++;
        if (expq.size() != 0) void'(expq.pop_front());
      end
      if (ivalid && iready) begin
        part.push_back(idata);
        if (fin) begin
          nw = build_word();
          expq.push_back(nw);
          produced++;
          part.delete();
        end
      end
      prev_hold = ovalid && !oready;
      prev_data = {31'd0, ovalid, odata};
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte until accepted (bounded).
  task automatic send(input logic [7:0] b, input bit fl);
    bit done;
    done   = 1'b0;
    ivalid = 1'b1;
    idata  = b;
    iflush = fl;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (iready) done = 1'b1;
      cyc();
    end
    if (!done) check("send_timeout", 64'(0), 64'(1));
    ivalid = 1'b0;
    iflush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, guard, d0, p0;

    // Reset state; iready is combinational and high during reset.
    #12;
    check("rst_iready", 64'(iready), 64'(1));
    check("rst_ovalid", 64'(ovalid), 64'(0));
    check("rst_odata", 64'(odata), 64'(0));
    cyc();
    rst = 1'b1;
    cyc();

    // Test 1: back-to-back word, consumer ready.
    oready = 1'b1;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    @(negedge clk);
    check("t1_ovalid", 64'(ovalid), 64'(1));
    check("t1_odata", 64'(odata), 64'h04030201);
    check("t4_odata_msb", 64'(odata_r), 64'h01020304);
    cyc();
    @(negedge clk);
    check("t1_ovalid_drop", 64'(ovalid), 64'(0));
    cyc();

    // Test 2: stall on the final byte while the slot is held.
    oready = 1'b0;
    for (int i = 8'h10; i <= 8'h16; i++) send(8'(i), 1'b0);
    ivalid = 1'b1;
    idata  = 8'h17;
    @(negedge clk);
    check("t2_stall", 64'(iready), 64'(0));
    check("t2_held", 64'(odata), 64'h13121110);
    cyc();
    @(negedge clk);
    check("t2_stall2", 64'(iready), 64'(0));
    cyc();
    oready = 1'b1;
    @(negedge clk);
    check("t2_release", 64'(iready), 64'(1));
    cyc();
    ivalid = 1'b0;
    @(negedge clk);
    check("t2_nobubble", 64'(ovalid), 64'(1));
    check("t2_odata", 64'(odata), 64'h17161514);
    cyc();

    // Test 3: asynchronous reset mid-fill with a word held.
    oready = 1'b0;
    for (int i = 8'h41; i <= 8'h44; i++) send(8'(i), 1'b0);
    send(8'h21, 1'b0);
    send(8'h22, 1'b0);
    rst = 1'b0;
    #1;
    check("t3_ovalid", 64'(ovalid), 64'(0));
    check("t3_odata", 64'(odata), 64'(0));
    check("t3_odata_msb", 64'(odata_r), 64'(0));
    cyc();
    rst = 1'b1;
    oready = 1'b1;
    for (int i = 8'h31; i <= 8'h34; i++) send(8'(i), 1'b0);
    @(negedge clk);
    check("t3_after", 64'(odata), 64'h34333231);
    cyc();

`ifdef PP_PACKER_FLUSH_EN
    // Test 5: flush after two bytes, then a full word.
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    @(negedge clk);
    check("t5_odata", 64'(odata), 64'h0000BBAA);
    check("t5_okeep", 64'(okeep), 64'h3);
    cyc();
    for (int i = 8'hC1; i <= 8'hC4; i++) send(8'(i), 1'b0);
    @(negedge clk);
    check("t5_okeep_full", 64'(okeep), 64'hF);
    cyc();
`endif

    // Test 6: random valid/ready traffic over 1000 bytes.
    d0 = drained;
    p0 = produced;
    sent = 0;
    guard = 0;
    while (sent < 1000 && guard < 8000) begin
      oready = ($urandom % 2) != 0;
      ivalid = ($urandom % 3) != 0;
      idata  = 8'($urandom);
      iflush = FLUSH && ivalid && (($urandom % 8) == 0);
      @(negedge clk);
      if (ivalid && iready) sent++;
      cyc();
      guard++;
    end
    check("t6_sent", 64'(sent), 64'(1000));
    ivalid = 1'b0;
    iflush = 1'b0;
    oready = 1'b1;
    repeat (4) cyc();
    check("t6_drained", 64'(drained - d0), 64'(produced - p0));
    check("t6_empty", 64'(ovalid), 64'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pp_packer.md
Name: pp_packer

Overview:
- Downstream stage of the 8-bit valid/ready byte pipeline (the increment stage).
- Collects NBYTE consecutive accepted bytes into one wide word and emits it on a valid/ready output.
- Sustains 1 byte/cycle when the consumer keeps oready high.
- Bridges the byte pipeline to word-wide consumers.

Parameters:
- NBYTE, 4: bytes per output word; legal range 2..16.
- LSB_FIRST, 1: 1 = first accepted byte goes to odata[7:0]; 0 = first byte goes to the most significant byte.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- ivalid  in  1  input byte valid.
- iready  out  1  input byte accepted when ivalid && iready.
- idata  in  8  input byte.
- ovalid  out  1  output word valid.
- oready  in  1  downstream ready.
- odata  out  8*NBYTE  packed word.
- iflush  in  1  present only with PP_PACKER_FLUSH_EN; marks the last byte of a burst.
- okeep  out  NBYTE  present only with PP_PACKER_FLUSH_EN; per-byte valid mask.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-low.
- Reset values: ovalid=0, odata=0, okeep=0. Internal byte counter cnt=0, assembly register=0.
- iready is reset-independent combinational logic; during reset it evaluates to 1.
- State:
  - cnt runs 0..NBYTE-1; it is the FILL state index.
  - Output slot: one register holding odata/okeep, flagged by ovalid.
- Accept: a byte is accepted on a cycle with ivalid && iready. It is written to byte lane k = cnt of the assembly register (lane mapping per LSB_FIRST), and cnt increments.
- Last byte: when cnt == NBYTE-1 and a byte is accepted:
  - The assembly bytes plus idata are loaded into the output slot on the same edge.
  - ovalid=1 on the next cycle, so latency is 1 cycle from the last-byte accept to ovalid.
  - cnt wraps to 0 and the assembly register clears to 0.
- iready = (cnt != NBYTE-1) || !ovalid || oready.
  - Non-final bytes are always accepted.
  - The final byte stalls only while the slot is full and not draining.
- Output handshake:
  - ovalid, odata and okeep hold stable while ovalid && !oready.
  - The slot clears on ovalid && oready unless it is reloaded on the same edge.
- Simultaneous drain and load: if ovalid && oready && final byte accepted in the same cycle, the new word replaces the old one. ovalid stays 1, with no bubble.
- ivalid gaps: cnt and the assembly register hold; no timeout.
- Back-pressure never drops or duplicates bytes. Output byte order equals input order.
- idata is not inspected; all 256 values are legal.
- Reset mid-fill discards partial bytes and any held word.

Optional Feature:
- Macro: PP_PACKER_FLUSH_EN.
- With the macro:
  - iflush and okeep ports exist.
  - An accepted byte with iflush=1 is treated as final regardless of cnt. The word loads the lanes filled so far plus this byte; unfilled lanes are 0.
  - okeep bit k=1 for each filled lane k, mapped like odata lanes.
  - The iready stall rule applies to a flush byte exactly as to a cnt==NBYTE-1 byte.
  - Full words carry okeep all-ones.
- Without the macro:
  - iflush and okeep are absent.
  - Every word is exactly NBYTE bytes.

Decomposition:
- Package pp_pkg:
  - byte_t (logic [7:0]).
  - A cnt-width constant function, $clog2(NBYTE) clamped to a minimum of 1.
  - Lane-index helper for LSB_FIRST mapping.
- Sub-module pp_out_slot:
  - Generic single-entry valid/ready output register, parameterised by width.
  - Ports: load, load data, oready; outputs ovalid, data, and "free" (= !ovalid || oready).
- The top level holds the counter, the assembly register and the iready logic.

Test Plan (NBYTE=4 unless stated):
1. 0x01,0x02,0x03,0x04 back-to-back, oready=1:
   - iready=1 throughout.
   - ovalid=1 the cycle after 0x04 is accepted, with odata=0x04030201.
   - ovalid drops the following cycle.
2. 0x10..0x17 with oready=0:
   - Word 0x13121110 is held stable.
   - 0x14..0x16 are accepted; iready=0 while 0x17 is offered.
   - Raising oready accepts 0x17 in the same cycle the first word drains.
   - Next word is 0x17161514 with no ovalid bubble.
3. Assert rst after 0x21,0x22 are accepted:
   - ovalid=0 and odata=0 immediately (async).
   - After release, 0x31..0x34 yield 0x34333231 with no stale bytes.
4. LSB_FIRST=0 with 0x01..0x04 -> odata=0x01020304.
5. PP_PACKER_FLUSH_EN, 0xAA then 0xBB with iflush=1 -> odata=0x0000BBAA, okeep=4'b0011. The next 4 bytes give okeep=4'b1111.
6. Random ivalid/oready toggling over 1000 bytes:
   - The scoreboard sees every byte exactly once, in order.
   - No odata/ovalid change is observed while ovalid && !oready.
